vga_timing_gen: RTL and testbench

// - Drives the pixel-coordinate interface used by every sprite/ROM pixel

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator.
// Produces pixel coordinates, a visible-region flag, active-low syncs and
// line/frame pulses. The syncs are re-timed through a short delay line so
// they stay aligned with colour outputs from downstream pixel stages.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1,   // extra hs/vs register stages, 0..4
    parameter int FRAME_W    = 16
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               en,
    output logic [9:0]         DrawX,
    output logic [9:0]         DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0]         hc_q, hc_d;
    logic [9:0]         vc_q, vc_d;
    logic               blank_q, blank_d;
    logic               hs_raw_q, hs_raw_d;
    logic               vs_raw_q, vs_raw_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    // Next-state counters and decodes; the decodes look at the next-state
    // counters so the registered flags line up with the registered coordinates.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        hc_d = hc_q;
        vc_d = vc_q;
        if (en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end

        // With en=0 the counters hold, so these decodes reproduce the held values.
        blank_d  = (hc_d < H_VIS) && (vc_d < V_VIS);
        hs_raw_d = !((hc_d >= H_SYNC_FIRST) && (hc_d <= H_SYNC_LAST));
        vs_raw_d = !((vc_d >= V_SYNC_FIRST) && (vc_d <= V_SYNC_LAST));

        line_start_d  = en && (hc_d == '0);
        frame_start_d = en && (hc_d == '0) && (vc_d == '0);

        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + FRAME_W'(1);
        end
    end

    // Timing state registers with asynchronous reset to the last position of a frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            blank_q       <= 1'b0;
            hs_raw_q      <= 1'b1;
            vs_raw_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            blank_q       <= blank_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hs_raw_q;
            assign vs = vs_raw_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_dly_q;
            logic [SYNC_DELAY-1:0] vs_dly_q;

            // Sync delay line; shifts only while timing advances so it freezes with the counters.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    // NOTE: the delay line is reset to the idle (high) sync level
                    // so no spurious sync pulse reaches the monitor after reset.
                    hs_dly_q <= '1;
                    vs_dly_q <= '1;
                end else if (en) begin
                    hs_dly_q[0] <= hs_raw_q;
                    vs_dly_q[0] <= vs_raw_q;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_dly_q[i] <= hs_dly_q[i-1];
                        vs_dly_q[i] <= vs_dly_q[i-1];
                    end
                end
            end

            assign hs = hs_dly_q[SYNC_DELAY-1];
            assign vs = vs_dly_q[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    // Pulses are masked directly by en so they read 0 for as long as timing is held.
    assign line_start  = line_start_q && en;
    assign frame_start = frame_start_q && en;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen.
// u_dut: default timing, SYNC_DELAY=1. u_d0/u_d3: default timing with
// SYNC_DELAY 0 and 3. u_sm: reduced 16x8 timing (128-cycle frame,
// FRAME_W=2) so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic en = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [9:0] dut_x, dut_y;
    logic dut_blank, dut_hs, dut_vs, dut_ls, dut_fs;
    logic [15:0] dut_fc;

    logic [9:0] d0_x, d0_y;
    logic d0_blank, d0_hs, d0_vs, d0_ls, d0_fs;
    logic [15:0] d0_fc;

    logic [9:0] d3_x, d3_y;
    logic d3_blank, d3_hs, d3_vs, d3_ls, d3_fs;
    logic [15:0] d3_fc;

    logic [9:0] sm_x, sm_y;
    logic sm_blank, sm_hs, sm_vs, sm_ls, sm_fs;
    logic [1:0] sm_fc;

    vga_timing_gen u_dut (
        .vga_clk(clk), .reset_n(reset_n), .en(en),
        .DrawX(dut_x), .DrawY(dut_y), .blank(dut_blank), .hs(dut_hs), .vs(dut_vs),
        .line_start(dut_ls), .frame_start(dut_fs), .frame_count(dut_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
        .vga_clk(clk), .reset_n(reset_n), .en(en),
        .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank), .hs(d0_hs), .vs(d0_vs),
        .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
        .vga_clk(clk), .reset_n(reset_n), .en(en),
        .DrawX(d3_x), .DrawY(d3_y), .blank(d3_blank), .hs(d3_hs), .vs(d3_vs),
        .line_start(d3_ls), .frame_start(d3_fs), .frame_count(d3_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_DELAY(1), .FRAME_W(2)
    ) u_sm (
        .vga_clk(clk), .reset_n(reset_n), .en(en),
        .DrawX(sm_x), .DrawY(sm_y), .blank(sm_blank), .hs(sm_hs), .vs(sm_vs),
        .line_start(sm_ls), .frame_start(sm_fs), .frame_count(sm_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++; if (dut_x !== 10'd799) begin errors++; $display("FAIL reset_x got %0d exp 799", dut_x); end
        checks++; if (dut_y !== 10'd524) begin errors++; $display("FAIL reset_y got %0d exp 524", dut_y); end
        checks++; if (dut_blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", dut_blank); end
        checks++; if (dut_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", dut_hs); end
        checks++; if (dut_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", dut_vs); end
        checks++; if (dut_ls !== 1'b0) begin errors++; $display("FAIL reset_line_start got %b exp 0", dut_ls); end
        checks++; if (dut_fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", dut_fs); end
        checks++; if (dut_fc !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", dut_fc); end
        checks++; if (d0_hs !== 1'b1) begin errors++; $display("FAIL reset_d0_hs got %b exp 1", d0_hs); end
        checks++; if (sm_x !== 10'd15 || sm_y !== 10'd7) begin errors++; $display("FAIL reset_sm_xy got %0d,%0d exp 15,7", sm_x, sm_y); end
        reset_n = 1'b1;
    endtask

    task automatic test_first_edge();
        tick();
        checks++; if (dut_x !== 10'd0 || dut_y !== 10'd0) begin errors++; $display("FAIL first_xy got %0d,%0d exp 0,0", dut_x, dut_y); end
        checks++; if (dut_blank !== 1'b1) begin errors++; $display("FAIL first_blank got %b exp 1", dut_blank); end
        checks++; if (dut_ls !== 1'b1) begin errors++; $display("FAIL first_line_start got %b exp 1", dut_ls); end
        checks++; if (dut_fs !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b exp 1", dut_fs); end
        checks++; if (dut_fc !== 16'd1) begin errors++; $display("FAIL first_frame_count got %0d exp 1", dut_fc); end
        checks++; if (d3_hs !== 1'b1 || d3_vs !== 1'b1) begin errors++; $display("FAIL first_d3_sync got %b%b exp 11", d3_hs, d3_vs); end
        tick();
        checks++; if (dut_x !== 10'd1) begin errors++; $display("FAIL second_x got %0d exp 1", dut_x); end
        checks++; if (dut_ls !== 1'b0 || dut_fs !== 1'b0) begin errors++; $display("FAIL second_pulses got %b%b exp 00", dut_ls, dut_fs); end
        checks++; if (dut_fc !== 16'd1) begin errors++; $display("FAIL second_frame_count got %0d exp 1", dut_fc); end
    endtask

    task automatic test_line();
        int d0_first = -1, du_first = -1, d3_first = -1;
        int d0_cnt = 0, du_cnt = 0, d3_cnt = 0;
        ticks(638);
        checks++; if (dut_x !== 10'd639 || dut_blank !== 1'b1) begin errors++; $display("FAIL line_x639 got x=%0d blank=%b exp 639,1", dut_x, dut_blank); end
        tick();
        checks++; if (dut_x !== 10'd640 || dut_blank !== 1'b0) begin errors++; $display("FAIL line_x640 got x=%0d blank=%b exp 640,0", dut_x, dut_blank); end
        ticks(15);
        checks++; if (dut_x !== 10'd655 || {d0_hs, dut_hs, d3_hs} !== 3'b111) begin errors++; $display("FAIL line_hs_pre got x=%0d hs=%b%b%b exp 655,111", dut_x, d0_hs, dut_hs, d3_hs); end
        for (int i = 0; i < 120; i++) begin
            tick();
            if (d0_hs === 1'b0) begin d0_cnt++; if (d0_first < 0) d0_first = int'(dut_x); end
            if (dut_hs === 1'b0) begin du_cnt++; if (du_first < 0) du_first = int'(dut_x); end
            if (d3_hs === 1'b0) begin d3_cnt++; if (d3_first < 0) d3_first = int'(dut_x); end
        end
        checks++; if (d0_first != 656) begin errors++; $display("FAIL hs_fall_delay0 got x=%0d exp 656", d0_first); end
        checks++; if (du_first != 657) begin errors++; $display("FAIL hs_fall_delay1 got x=%0d exp 657", du_first); end
        checks++; if (d3_first != 659) begin errors++; $display("FAIL hs_fall_delay3 got x=%0d exp 659", d3_first); end
        checks++; if (d0_cnt != 96 || du_cnt != 96 || d3_cnt != 96) begin errors++; $display("FAIL hs_width got %0d/%0d/%0d exp 96/96/96", d0_cnt, du_cnt, d3_cnt); end
        ticks(24);
        checks++; if (dut_x !== 10'd799 || dut_y !== 10'd0 || dut_ls !== 1'b0) begin errors++; $display("FAIL line_end got x=%0d y=%0d ls=%b exp 799,0,0", dut_x, dut_y, dut_ls); end
        tick();
        checks++; if (dut_x !== 10'd0 || dut_y !== 10'd1) begin errors++; $display("FAIL line_wrap got %0d,%0d exp 0,1", dut_x, dut_y); end
        checks++; if (dut_ls !== 1'b1 || dut_fs !== 1'b0) begin errors++; $display("FAIL line_wrap_pulses got ls=%b fs=%b exp 1,0", dut_ls, dut_fs); end
        tick();
        checks++; if (dut_x !== 10'd1 || dut_ls !== 1'b0) begin errors++; $display("FAIL line_after got x=%0d ls=%b exp 1,0", dut_x, dut_ls); end
    endtask

    task automatic test_en_hold();
        ticks(3499);
        checks++; if (dut_x !== 10'd300 || dut_y !== 10'd5) begin errors++; $display("FAIL hold_pos got %0d,%0d exp 300,5", dut_x, dut_y); end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (dut_x !== 10'd300 || dut_y !== 10'd5) begin errors++; $display("FAIL hold_xy[%0d] got %0d,%0d exp 300,5", i, dut_x, dut_y); end
            checks++; if (dut_ls !== 1'b0 || dut_fs !== 1'b0) begin errors++; $display("FAIL hold_pulses[%0d] got %b%b exp 00", i, dut_ls, dut_fs); end
            checks++; if (dut_blank !== 1'b1) begin errors++; $display("FAIL hold_blank[%0d] got %b exp 1", i, dut_blank); end
        end
        en = 1'b1;
        tick();
        checks++; if (dut_x !== 10'd301 || dut_y !== 10'd5) begin errors++; $display("FAIL hold_resume got %0d,%0d exp 301,5", dut_x, dut_y); end
    endtask

    task automatic test_mid_reset();
        ticks(99);
        checks++; if (dut_x !== 10'd400 || dut_y !== 10'd5) begin errors++; $display("FAIL mid_pos got %0d,%0d exp 400,5", dut_x, dut_y); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dut_x !== 10'd799 || dut_y !== 10'd524) begin errors++; $display("FAIL mid_reset_xy got %0d,%0d exp 799,524", dut_x, dut_y); end
        checks++; if (dut_blank !== 1'b0 || dut_hs !== 1'b1 || dut_vs !== 1'b1) begin errors++; $display("FAIL mid_reset_flags got blank=%b hs=%b vs=%b exp 0,1,1", dut_blank, dut_hs, dut_vs); end
        checks++; if (dut_fc !== 16'd0) begin errors++; $display("FAIL mid_reset_frame_count got %0d exp 0", dut_fc); end
        reset_n = 1'b1;
        tick();
        checks++; if (dut_x !== 10'd0 || dut_y !== 10'd0 || dut_fs !== 1'b1 || dut_fc !== 16'd1) begin errors++; $display("FAIL mid_release got %0d,%0d fs=%b fc=%0d exp 0,0,1,1", dut_x, dut_y, dut_fs, dut_fc); end
    endtask

    task automatic test_frame();
        int period = -1, blank_cnt = 0, vs_cnt = 0, vs_x = -1, vs_y = -1;
        checks++; if (sm_x !== 10'd0 || sm_y !== 10'd0 || sm_fs !== 1'b1) begin errors++; $display("FAIL frame_start_pos got %0d,%0d fs=%b exp 0,0,1", sm_x, sm_y, sm_fs); end
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (sm_fs === 1'b1 && period < 0) period = i;
            if (sm_blank === 1'b1) blank_cnt++;
            if (sm_vs === 1'b0) begin
                vs_cnt++;
                if (vs_x < 0) begin vs_x = int'(sm_x); vs_y = int'(sm_y); end
            end
        end
        checks++; if (period != 128) begin errors++; $display("FAIL frame_period got %0d exp 128", period); end
        checks++; if (blank_cnt != 32) begin errors++; $display("FAIL frame_blank_count got %0d exp 32", blank_cnt); end
        checks++; if (vs_cnt != 32) begin errors++; $display("FAIL frame_vs_width got %0d exp 32", vs_cnt); end
        checks++; if (vs_x != 1 || vs_y != 5) begin errors++; $display("FAIL frame_vs_start got %0d,%0d exp 1,5", vs_x, vs_y); end
        checks++; if (sm_fc !== 2'd2) begin errors++; $display("FAIL frame_count got %0d exp 2", sm_fc); end
    endtask

    task automatic test_frame_count_wrap();
        ticks(128);
        checks++; if (sm_fc !== 2'd3) begin errors++; $display("FAIL wrap_pre got %0d exp 3", sm_fc); end
        ticks(128);
        checks++; if (sm_fc !== 2'd0 || sm_fs !== 1'b1) begin errors++; $display("FAIL wrap got fc=%0d fs=%b exp 0,1", sm_fc, sm_fs); end
    endtask

    task automatic test_stall_period();
        int period = 60;
        bit found = 1'b0;
        ticks(50);
        en = 1'b0;
        ticks(10);
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            period++;
            if (sm_fs === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL stall_timeout got no frame_start exp one within 200 cycles"); end
        checks++; if (period != 138) begin errors++; $display("FAIL stall_period got %0d exp 138", period); end
    endtask

    task automatic test_pulse_gating();
        checks++; if (sm_ls !== 1'b1 || sm_fs !== 1'b1 || sm_fc !== 2'd1) begin errors++; $display("FAIL gate_pre got ls=%b fs=%b fc=%0d exp 1,1,1", sm_ls, sm_fs, sm_fc); end
        en = 1'b0;
        #1;
        checks++; if (sm_ls !== 1'b0 || sm_fs !== 1'b0) begin errors++; $display("FAIL gate_immediate got %b%b exp 00", sm_ls, sm_fs); end
        tick();
        checks++; if (sm_x !== 10'd0 || sm_ls !== 1'b0 || sm_fs !== 1'b0 || sm_fc !== 2'd1) begin errors++; $display("FAIL gate_held got x=%0d ls=%b fs=%b fc=%0d exp 0,0,0,1", sm_x, sm_ls, sm_fs, sm_fc); end
        en = 1'b1;
        tick();
        checks++; if (sm_x !== 10'd1 || sm_ls !== 1'b0 || sm_fc !== 2'd1) begin errors++; $display("FAIL gate_resume got x=%0d ls=%b fc=%0d exp 1,0,1", sm_x, sm_ls, sm_fc); end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_line();
        test_en_hold();
        test_mid_reset();
        test_frame();
        test_frame_count_wrap();
        test_stall_period();
        test_pulse_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
